hm_violation_reporter: RTL and testbench
========================================

# hm_violation_reporter

Downstream consumer of the deadline unit's `tdi_error` code. It detects each new non-zero violation code and tags it with the current guest and time. Tagged events are queued in a small show-ahead FIFO. The block raises an acknowledge-handshaked interrupt toward the hypervisor CPU and keeps saturating per-guest violation counters for software readout.

## Interface
- `DEPTH`, 4, event FIFO depth; power of two, ≥2
- `CNT_W`, 8, width of each per-guest violation counter
- `clk`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-high
- `i_enable`  in  1  capture enable; 0 = ignore violation codes
- `i_tdi_error`  in  3  violation code from deadline unit; 0 = none
- `i_current_guest`  in  3  guest id currently running
- `i_current_time`  in  32  free-running time base
- `i_pop`  in  1  discard FIFO head (1-cycle pulse)
- `i_ack`  in  1  hypervisor interrupt acknowledge
- `i_cnt_sel`  in  3  guest counter select
- `i_cnt_clr`  in  1  clear counter selected by `i_cnt_sel`
- `i_clear_drop`  in  1  clear sticky drop flag
- `o_valid`  out  1  FIFO non-empty
- `o_event_code`  out  3  head entry violation code
- `o_event_guest`  out  3  head entry guest id
- `o_event_time`  out  32  head entry timestamp
- `o_irq`  out  1  interrupt request
- `o_drop`  out  1  sticky: at least one event lost to a full FIFO
- `o_cnt`  out  CNT_W  counter of guest `i_cnt_sel` (combinational mux)

## Operation
- `prev_code` register: loaded with `i_tdi_error` every cycle, regardless of `i_enable`.
- An event is generated in cycle N when all of these hold: `i_enable`=1, `i_tdi_error`≠0, `i_tdi_error`≠`prev_code`.
  - A held (sticky) code produces exactly one event.
  - A change from one non-zero code to another produces a new event.
- Event payload is {`i_tdi_error`, `i_current_guest`, `i_current_time`}, all sampled in cycle N.
- FIFO:
  - Circular buffer with read/write pointers of log2(DEPTH) bits, wrapping naturally.
  - Occupancy count is log2(DEPTH)+1 bits.
  - Head outputs are driven from storage at the read pointer, show-ahead.
  - Push while full with no pop: the event is dropped, `o_drop` is set, and the FIFO is unchanged.
  - Push and pop in the same cycle while full: both happen, count unchanged, no drop.
  - Push and pop in the same cycle while empty: the push is accepted, the pop is ignored.
  - `i_pop` while empty is ignored.
  - `o_drop` set and `i_clear_drop` in the same cycle: set wins.
- Counters, one per guest (8 × CNT_W):
  - Every generated event, accepted or dropped, increments `cnt[i_current_guest]`.
  - Counters saturate at 2^CNT_W−1.
  - `i_cnt_clr` zeroes `cnt[i_cnt_sel]`.
  - Clear and increment of the same guest in the same cycle: result is 1.
- IRQ FSM, states IDLE, RAISE, SERVICE:
  - IDLE (`o_irq`=0): moves to RAISE when count≠0.
  - RAISE (`o_irq`=1): moves to SERVICE on `i_ack`.
  - SERVICE (`o_irq`=0): moves to IDLE when count=0. Events pushed during SERVICE are drained without a new IRQ.
  - `i_ack` is ignored outside RAISE.
- `i_pop` is honoured in every FSM state.

## Timing
- Reset values:
  - FIFO empty; `o_valid`=0; `o_event_*`=0 (storage cleared).
  - `o_irq`=0; FSM in IDLE; `o_drop`=0.
  - All counters 0; `prev_code`=0.
- Reset mid-operation discards all queued events and returns the FSM to IDLE in the same edge.
- Latency for an event sampled in cycle N:
  - Entry written at edge end of N; `o_valid`=1 from cycle N+1.
  - Counter updated and visible on `o_cnt` from N+1.
  - FSM enters RAISE at edge end of N+1; `o_irq`=1 from N+2.
- Pop in cycle M: the next entry (or `o_valid`=0) appears in cycle M+1.
- `i_ack` in cycle A: `o_irq`=0 from A+1.
- Throughput: one event per cycle; one pop per cycle.
- All outputs are registered except `o_cnt` and `o_event_*`, which are muxes of registers.

## Test plan
- Reset, then `i_tdi_error`=3'b001 held 10 cycles, guest 2, time 0x100 → exactly one entry {1,2,0x100}; `o_valid` rises 1 cycle later; `o_irq` rises 2 cycles later; cnt[2]=1.
- Codes 1→2→0→2 on consecutive cycles, guest 5 → three entries in order (1,2,2); cnt[5]=3.
- Six distinct events with no pop (DEPTH=4) → four entries kept, `o_drop`=1, counter=6. Then one cycle with push and pop while full → count stays 4, oldest entry removed.
- IRQ handshake: event → `o_irq`=1; `i_ack` → `o_irq`=0. Push one more during SERVICE, pop both → FSM returns to IDLE with no second IRQ. Then a new event → `o_irq` is asserted again.
- Counter saturation with CNT_W=2: five events on guest 0 → `o_cnt`=3. Then `i_cnt_clr` together with an event on guest 0 → `o_cnt`=1.
- `i_enable`=0 while the code goes 0→4, then `i_enable`=1 while 4 is held → no event. Reset asserted with 3 entries queued → `o_valid`=0 and `o_irq`=0 next cycle.

Source files
------------

// File: rtl/hm_violation_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : hm_violation_reporter
//  Description : Watches the deadline unit's violation code. Each new
//                non-zero code becomes an event tagged with the running
//                guest and the current time. Events are queued in a
//                show-ahead FIFO, announced by an acknowledge-handshaked
//                interrupt, and counted in saturating per-guest counters.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                i_enable              - capture enable
//                i_tdi_error           - violation code (0 = none)
//                i_current_guest/time  - event tag sources
//                i_pop                 - discard FIFO head
//                i_ack                 - interrupt acknowledge
//                i_cnt_sel/i_cnt_clr   - counter readout select / clear
//                i_clear_drop          - clear sticky drop flag
//                o_valid, o_event_*    - FIFO non-empty and head entry
//                o_irq, o_drop, o_cnt  - interrupt, sticky drop, counter
//  Revision    : 1.0 - initial release
// ============================================================================
module hm_violation_reporter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_enable,
    input  wire logic [2:0]       i_tdi_error,
    input  wire logic [2:0]       i_current_guest,
    input  wire logic [31:0]      i_current_time,
    input  wire logic             i_pop,
    input  wire logic             i_ack,
    input  wire logic [2:0]       i_cnt_sel,
    input  wire logic             i_cnt_clr,
    input  wire logic             i_clear_drop,
    output logic                  o_valid,
    output logic [2:0]            o_event_code,
    output logic [2:0]            o_event_guest,
    output logic [31:0]           o_event_time,
    output logic                  o_irq,
    output logic                  o_drop,
    output logic [CNT_W-1:0]      o_cnt
);

    localparam int                c_aw       = $clog2(DEPTH);
    localparam logic [c_aw:0]     c_depth    = (c_aw+1)'(DEPTH);
    localparam logic [c_aw:0]     c_cnt_one  = (c_aw+1)'(1);
    localparam logic [c_aw-1:0]   c_ptr_one  = c_aw'(1);
    localparam logic [CNT_W-1:0]  c_sat      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_inc      = CNT_W'(1);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_raise   = 2'd1;
    localparam logic [1:0] c_st_service = 2'd2;

    // ------------------------------------------------------------------
    // Event detection: a code counts once, on the cycle it first appears
    // ------------------------------------------------------------------
    logic [2:0] r_prev_code;
    logic       w_event;

    always_ff @(posedge clk) begin
        if (reset) r_prev_code <= 3'd0;
        else       r_prev_code <= i_tdi_error;
    end

    assign w_event = i_enable && (i_tdi_error != 3'd0) && (i_tdi_error != r_prev_code);

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [2:0]      r_code  [DEPTH];
    logic [2:0]      r_guest [DEPTH];
    logic [31:0]     r_time  [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic [c_aw:0]   w_count_next;
    logic            r_valid;
    logic            r_drop;
    logic            w_do_pop;
    logic            w_do_push;
    logic            w_drop_evt;

    // A pop on an empty FIFO is ignored; a pop on a full FIFO frees the
    // slot the simultaneous push needs.
    assign w_do_pop   = i_pop && (r_count != '0);
    assign w_do_push  = w_event && ((r_count != c_depth) || w_do_pop);
    assign w_drop_evt = w_event && !w_do_push;

    always_comb begin
        w_count_next = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_next = r_count + c_cnt_one;
            2'b01:   w_count_next = r_count - c_cnt_one;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_code[i]  <= 3'd0;
                r_guest[i] <= 3'd0;
                r_time[i]  <= 32'd0;
            end
        end else begin
            if (w_do_push) begin
                r_code[r_wr_ptr]  <= i_tdi_error;
                r_guest[r_wr_ptr] <= i_current_guest;
                r_time[r_wr_ptr]  <= i_current_time;
                r_wr_ptr          <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count <= w_count_next;
            r_valid <= (w_count_next != '0);
        end
    end

    // Setting the sticky flag takes priority over clearing it
    always_ff @(posedge clk) begin
        if (reset)             r_drop <= 1'b0;
        else if (w_drop_evt)   r_drop <= 1'b1;
        else if (i_clear_drop) r_drop <= 1'b0;
    end

    assign o_valid       = r_valid;
    assign o_drop        = r_drop;
    assign o_event_code  = r_code[r_rd_ptr];
    assign o_event_guest = r_guest[r_rd_ptr];
    assign o_event_time  = r_time[r_rd_ptr];

    // ------------------------------------------------------------------
    // Per-guest saturating violation counters (dropped events count too)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt [8];

    always_ff @(posedge clk) begin
        for (int g = 0; g < 8; g++) begin
            if (reset) begin
                r_cnt[g] <= '0;
            end else if (i_cnt_clr && (i_cnt_sel == 3'(g))) begin
                // Clear and increment together leaves exactly one count
                r_cnt[g] <= (w_event && (i_current_guest == 3'(g))) ? c_inc : '0;
            end else if (w_event && (i_current_guest == 3'(g)) && (r_cnt[g] != c_sat)) begin
                r_cnt[g] <= r_cnt[g] + c_inc;
            end
        end
    end

    assign o_cnt = r_cnt[i_cnt_sel];

    // ------------------------------------------------------------------
    // Interrupt FSM: one IRQ per burst; SERVICE drains without re-raising
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_irq;
    logic       w_irq_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_irq   <= w_irq_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:    if (r_count != '0) w_state_next = c_st_raise;
            c_st_raise:   if (i_ack)         w_state_next = c_st_service;
            c_st_service: if (r_count == '0) w_state_next = c_st_idle;
            default:                         w_state_next = c_st_idle;
        endcase
    end

    // The IRQ flop is loaded with the decode of the next state so that it
    // tracks RAISE exactly while remaining a register output.
    always_comb begin
        w_irq_next = (w_state_next == c_st_raise);
    end

    assign o_irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_hm_violation_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hm_violation_reporter
//  Description : Self-checking bench for hm_violation_reporter. Two
//                instances (8-bit and 2-bit counters) share one stimulus;
//                a queue-based model predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hm_violation_reporter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_enable;
    logic [2:0]  i_tdi_error;
    logic [2:0]  i_current_guest;
    logic [31:0] i_current_time;
    logic        i_pop;
    logic        i_ack;
    logic [2:0]  i_cnt_sel;
    logic        i_cnt_clr;
    logic        i_clear_drop;

    logic        valid_a, irq_a, drop_a, valid_b, irq_b, drop_b;
    logic [2:0]  code_a, guest_a, code_b, guest_b;
    logic [31:0] time_a, time_b;
    logic [7:0]  cnt_a;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    hm_violation_reporter #(.DEPTH(DEPTH), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .i_enable(i_enable), .i_tdi_error(i_tdi_error),
        .i_current_guest(i_current_guest), .i_current_time(i_current_time),
        .i_pop(i_pop), .i_ack(i_ack), .i_cnt_sel(i_cnt_sel), .i_cnt_clr(i_cnt_clr),
        .i_clear_drop(i_clear_drop), .o_valid(valid_a), .o_event_code(code_a),
        .o_event_guest(guest_a), .o_event_time(time_a), .o_irq(irq_a),
        .o_drop(drop_a), .o_cnt(cnt_a)
    );

    hm_violation_reporter #(.DEPTH(DEPTH), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .i_enable(i_enable), .i_tdi_error(i_tdi_error),
        .i_current_guest(i_current_guest), .i_current_time(i_current_time),
        .i_pop(i_pop), .i_ack(i_ack), .i_cnt_sel(i_cnt_sel), .i_cnt_clr(i_cnt_clr),
        .i_clear_drop(i_clear_drop), .o_valid(valid_b), .o_event_code(code_b),
        .o_event_guest(guest_b), .o_event_time(time_b), .o_irq(irq_b),
        .o_drop(drop_b), .o_cnt(cnt_b)
    );

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_pass  = 0;
    int n_total = 0;
    bit started = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: queue of events, plain counters, two IRQ flags
    // ------------------------------------------------------------------
    typedef struct {
        logic [2:0]  code;
        logic [2:0]  guest;
        logic [31:0] tstamp;
    } ev_t;

    ev_t        q[$];
    int         m_cnt8 [8];
    int         m_cnt2 [8];
    bit         m_drop;
    bit         m_irq;      // interrupt currently asserted
    bit         m_serv;     // acknowledged, waiting for queue to empty
    logic [2:0] m_prev;

    always @(posedge clk) begin
        int  sz;
        bit  ev, pop_ok, push_ok;
        ev_t e;
        if (reset) begin
            q.delete();
            for (int g = 0; g < 8; g++) begin
                m_cnt8[g] = 0;
                m_cnt2[g] = 0;
            end
            m_drop = 0; m_irq = 0; m_serv = 0; m_prev = 3'd0;
        end else begin
            sz      = q.size();
            ev      = i_enable && (i_tdi_error != 3'd0) && (i_tdi_error != m_prev);
            pop_ok  = i_pop && (sz > 0);
            push_ok = ev && ((sz < DEPTH) || pop_ok);
            if (ev && !push_ok)   m_drop = 1;
            else if (i_clear_drop) m_drop = 0;
            for (int g = 0; g < 8; g++) begin
                bit hit;
                hit = ev && (int'(i_current_guest) == g);
                if (i_cnt_clr && (int'(i_cnt_sel) == g)) begin
                    m_cnt8[g] = hit ? 1 : 0;
                    m_cnt2[g] = hit ? 1 : 0;
                end else if (hit) begin
                    m_cnt8[g] = (m_cnt8[g] + 1 > 255) ? 255 : m_cnt8[g] + 1;
                    m_cnt2[g] = (m_cnt2[g] + 1 > 3)   ? 3   : m_cnt2[g] + 1;
                end
            end
            if (!m_irq && !m_serv) begin
                if (sz != 0) m_irq = 1;
            end else if (m_irq) begin
                if (i_ack) begin m_irq = 0; m_serv = 1; end
            end else if (sz == 0) begin
                m_serv = 0;
            end
            if (pop_ok) void'(q.pop_front());
            if (push_ok) begin
                e.code = i_tdi_error; e.guest = i_current_guest; e.tstamp = i_current_time;
                q.push_back(e);
            end
            m_prev = i_tdi_error;
        end
    end

    // Compare process, sampled mid-cycle
    always @(negedge clk) begin
        if (started) begin
            chk("valid_a", 32'(valid_a), 32'(q.size() != 0));
            chk("valid_b", 32'(valid_b), 32'(q.size() != 0));
            chk("irq_a",   32'(irq_a),   32'(m_irq));
            chk("irq_b",   32'(irq_b),   32'(m_irq));
            chk("drop_a",  32'(drop_a),  32'(m_drop));
            chk("drop_b",  32'(drop_b),  32'(m_drop));
            chk("cnt_a",   32'(cnt_a),   32'(m_cnt8[i_cnt_sel]));
            chk("cnt_b",   32'(cnt_b),   32'(m_cnt2[i_cnt_sel]));
            if (q.size() != 0) begin
                chk("head_code_a",  32'(code_a),  32'(q[0].code));
                chk("head_guest_a", 32'(guest_a), 32'(q[0].guest));
                chk("head_time_a",  time_a,       q[0].tstamp);
                chk("head_code_b",  32'(code_b),  32'(q[0].code));
                chk("head_time_b",  time_b,       q[0].tstamp);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        i_tdi_error = 3'd0;
        i_ack = 1'b0;
        i_pop = 1'b1;
        repeat (5) tick();
        i_pop = 1'b0;
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        i_clear_drop = 1'b1;
        tick();
        i_clear_drop = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1; i_enable = 1'b1; i_tdi_error = 3'd0; i_current_guest = 3'd0;
        i_current_time = 32'd0; i_pop = 1'b0; i_ack = 1'b0; i_cnt_sel = 3'd0;
        i_cnt_clr = 1'b0; i_clear_drop = 1'b0;
        tick();
        tick();
        started = 1'b1;
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_irq",   32'(irq_a),   32'd0);
        chk("rst_drop",  32'(drop_a),  32'd0);
        chk("rst_code",  32'(code_a),  32'd0);
        chk("rst_time",  time_a,       32'd0);
        chk("rst_cnt",   32'(cnt_a),   32'd0);
        reset = 1'b0;
        tick();

        // Held code produces one event; latency of valid / cnt / irq
        i_cnt_sel = 3'd2; i_current_guest = 3'd2; i_current_time = 32'h100; i_tdi_error = 3'd1;
        tick();
        chk("t1_valid_n1", 32'(valid_a), 32'd1);
        chk("t1_irq_n1",   32'(irq_a),   32'd0);
        chk("t1_cnt",      32'(cnt_a),   32'd1);
        chk("t1_head",     {code_a, guest_a, 26'd0}, {3'd1, 3'd2, 26'd0});
        chk("t1_time",     time_a,       32'h100);
        tick();
        chk("t1_irq_n2",   32'(irq_a),   32'd1);
        repeat (8) tick();
        chk("t1_cnt_held", 32'(cnt_a),   32'd1);
        i_pop = 1'b1;
        tick();
        i_pop = 1'b0;
        chk("t1_one_entry", 32'(valid_a), 32'd0);
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        chk("t1_ack_irq",  32'(irq_a),   32'd0);
        i_tdi_error = 3'd0;
        tick(); tick();

        // Codes 1 -> 2 -> 0 -> 2 on guest 5
        i_current_guest = 3'd5; i_cnt_sel = 3'd5;
        i_tdi_error = 3'd1; tick();
        i_tdi_error = 3'd2; tick();
        i_tdi_error = 3'd0; tick();
        i_tdi_error = 3'd2; tick();
        i_tdi_error = 3'd0;
        chk("t2_cnt",   32'(cnt_a),   32'd3);
        chk("t2_head0", 32'(code_a),  32'd1);
        chk("t2_guest", 32'(guest_a), 32'd5);
        i_pop = 1'b1;
        tick(); chk("t2_head1", 32'(code_a), 32'd2);
        tick(); chk("t2_head2", 32'(code_a), 32'd2);
        tick(); chk("t2_empty", 32'(valid_a), 32'd0);
        i_pop = 1'b0;
        drain();

        // Overflow: six events into a four-deep FIFO
        i_current_guest = 3'd3; i_cnt_sel = 3'd3;
        for (int i = 0; i < 6; i++) begin
            i_tdi_error = (i % 2 == 0) ? 3'd1 : 3'd2;
            i_current_time = 32'h200 + 32'(i);
            tick();
        end
        chk("t3_drop",  32'(drop_a), 32'd1);
        chk("t3_cnt_a", 32'(cnt_a),  32'd6);
        chk("t3_cnt_b", 32'(cnt_b),  32'd3);
        chk("t3_head",  time_a,      32'h200);
        i_tdi_error = 3'd1; i_current_time = 32'h206; i_pop = 1'b1;
        tick();
        i_pop = 1'b0; i_tdi_error = 3'd0;
        chk("t3_fullpp_head", time_a, 32'h201);
        chk("t3_fullpp_cnt",  32'(cnt_a), 32'd7);
        i_pop = 1'b1;
        repeat (3) tick();
        chk("t3_still_valid", 32'(valid_a), 32'd1);
        chk("t3_last",        time_a,       32'h206);
        tick();
        i_pop = 1'b0;
        chk("t3_empty", 32'(valid_a), 32'd0);
        drain();
        chk("t3_drop_clr", 32'(drop_a), 32'd0);

        // IRQ handshake, push during SERVICE, re-raise afterwards
        i_current_guest = 3'd1; i_cnt_sel = 3'd1;
        i_tdi_error = 3'd4; tick();
        chk("t4_irq_n1", 32'(irq_a), 32'd0);
        tick();
        chk("t4_irq_n2", 32'(irq_a), 32'd1);
        i_ack = 1'b1; tick(); i_ack = 1'b0;
        chk("t4_irq_ack", 32'(irq_a), 32'd0);
        i_tdi_error = 3'd5; tick(); i_tdi_error = 3'd0;
        i_pop = 1'b1; tick(); tick(); i_pop = 1'b0;
        chk("t4_drained", 32'(valid_a), 32'd0);
        tick(); tick();
        chk("t4_no_irq", 32'(irq_a), 32'd0);
        i_tdi_error = 3'd6; tick();
        chk("t4_re_n1", 32'(irq_a), 32'd0);
        tick();
        chk("t4_re_n2", 32'(irq_a), 32'd1);
        drain();

        // Saturation on the 2-bit instance, then clear + increment
        i_current_guest = 3'd0; i_cnt_sel = 3'd0;
        for (int i = 0; i < 5; i++) begin
            i_tdi_error = (i % 2 == 0) ? 3'd1 : 3'd2;
            tick();
        end
        chk("t5_sat_b", 32'(cnt_b), 32'd3);
        chk("t5_cnt_a", 32'(cnt_a), 32'd5);
        i_tdi_error = 3'd2; i_cnt_clr = 1'b1;
        tick();
        i_cnt_clr = 1'b0; i_tdi_error = 3'd0;
        chk("t5_clrinc_b", 32'(cnt_b), 32'd1);
        chk("t5_clrinc_a", 32'(cnt_a), 32'd1);
        drain();

        // Disabled capture while the code rises, then held code
        i_enable = 1'b0; i_tdi_error = 3'd0; tick();
        i_tdi_error = 3'd4; tick(); tick();
        i_enable = 1'b1; tick(); tick(); tick();
        chk("t6_no_event", 32'(valid_a), 32'd0);
        chk("t6_cnt",      32'(cnt_a),   32'd1);
        i_tdi_error = 3'd0; tick();
        i_current_guest = 3'd6;
        i_tdi_error = 3'd1; tick();
        i_tdi_error = 3'd2; tick();
        i_tdi_error = 3'd1; tick();
        i_tdi_error = 3'd0;
        chk("t6_queued", 32'(valid_a), 32'd1);
        chk("t6_irq",    32'(irq_a),   32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t6_rst_valid", 32'(valid_a), 32'd0);
        chk("t6_rst_irq",   32'(irq_a),   32'd0);
        tick();

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            i_enable        = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) != 0) i_tdi_error = 3'($urandom_range(0, 7));
            i_current_guest = 3'($urandom_range(0, 2));
            i_current_time  = $urandom;
            i_pop           = ($urandom_range(0, 2) == 0);
            i_ack           = ($urandom_range(0, 3) == 0);
            i_cnt_sel       = 3'($urandom_range(0, 7));
            i_cnt_clr       = ($urandom_range(0, 31) == 0);
            i_clear_drop    = ($urandom_range(0, 15) == 0);
            reset           = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; i_pop = 1'b0; i_ack = 1'b0; i_cnt_clr = 1'b0; i_clear_drop = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
